sha256_block_sequencer: RTL and testbench

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

---
 rtl/sha256_seq_pkg.sv | 17 +
 rtl/sha256_seq_fill.sv | 31 +++
 rtl/sha256_block_sequencer.sv | 151 +++++++++++++++
 tb/tb_sha256_block_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_seq_pkg.sv
// rtl/sha256_seq_pkg.sv - shared constants and state encoding for the sha256 block sequencer
package sha256_seq_pkg;

    localparam int BLOCK_W         = 512;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 16;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_ISSUE,
        ST_SKIP,
        ST_WAIT,
        ST_OUT
    } seq_state_t;

endpackage

// File: rtl/sha256_seq_fill.sv
// rtl/sha256_seq_fill.sv - 512-bit block assembly register and word index counter
module sha256_seq_fill
    import sha256_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  word,
    input  logic               last,
    output logic [BLOCK_W-1:0] block,
    output logic [IDX_W-1:0]   idx
);

    // Word 0 sits in the top bits; an early last clears every slot above it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block <= '0;
            idx   <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                if (i == int'(idx)) begin
                    block[BLOCK_W-1-WORD_W*i -: WORD_W] <= word;
                end else if (last && (i > int'(idx))) begin
                    block[BLOCK_W-1-WORD_W*i -: WORD_W] <= '0;
                end
            end
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - feeds message words as blocks to a sha256 core; watchdog under SHA256_SEQ_TIMEOUT_EN
module sha256_block_sequencer
    import sha256_seq_pkg::*;
#(
    parameter int DIGEST_W    = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   msg_word,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic                msg_last,
    output logic                core_init,
    output logic                core_next,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_ready,
    input  logic                core_digest_valid,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [DIGEST_W-1:0] dig_data,
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic                short_err,
    output logic                timeout_err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be positive");
    end

    seq_state_t       state;
    logic             first_blk;
    logic             final_blk;
    logic [IDX_W-1:0] fill_idx;
    logic             xfer;
    logic             idx_full;
    logic             blk_end;
    logic             tmo_hit;

    assign xfer     = msg_valid && msg_ready;
    assign idx_full = (fill_idx == IDX_W'(WORDS_PER_BLOCK - 1));
    assign blk_end  = xfer && (msg_last || idx_full);

    sha256_seq_fill u_fill (
        .clk   (clk),
        .rst   (rst),
        .wr_en (xfer),
        .word  (msg_word),
        .last  (msg_last),
        .block (core_block),
        .idx   (fill_idx)
    );

`ifdef SHA256_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_hit = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FILL;
            first_blk   <= 1'b1;
            final_blk   <= 1'b0;
            msg_ready   <= 1'b0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            dig_valid   <= 1'b0;
            dig_data    <= '0;
            short_err   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SHA256_SEQ_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            short_err   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SHA256_SEQ_TIMEOUT_EN
            tmo_cnt <= ((state == ST_ISSUE) || (state == ST_WAIT)) ? tmo_cnt + 1'b1 : '0;
`endif
            if (tmo_hit) begin
                // Abandon the message; the next one starts over with core_init.
                timeout_err <= 1'b1;
                first_blk   <= 1'b1;
                msg_ready   <= 1'b1;
                state       <= ST_FILL;
            end else begin
                case (state)
                    ST_FILL: begin
                        msg_ready <= 1'b1;
                        if (blk_end) begin
                            msg_ready <= 1'b0;
                            final_blk <= msg_last;
                            short_err <= msg_last && !idx_full;
                            // Core already idle: command goes out without an ISSUE cycle.
                            if (core_ready) begin
                                core_init <= first_blk;
                                core_next <= !first_blk;
                                first_blk <= 1'b0;
                                state     <= ST_SKIP;
                            end else begin
                                state <= ST_ISSUE;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (core_ready) begin
                            core_init <= first_blk;
                            core_next <= !first_blk;
                            first_blk <= 1'b0;
                            state     <= ST_SKIP;
                        end
                    end
                    ST_SKIP: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (core_ready && core_digest_valid) begin
                            if (final_blk) begin
                                dig_data  <= core_digest;
                                dig_valid <= 1'b1;
                                state     <= ST_OUT;
                            end else begin
                                msg_ready <= 1'b1;
                                state     <= ST_FILL;
                            end
                        end
                    end
                    ST_OUT: begin
                        if (dig_ready) begin
                            dig_valid <= 1'b0;
                            first_blk <= 1'b1;
                            msg_ready <= 1'b1;
                            state     <= ST_FILL;
                        end
                    end
                    default: begin
                        msg_ready <= 1'b0;
                        state     <= ST_FILL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb/tb_sha256_block_sequencer.sv - scoreboard bench with a behavioural sha256 core model
module tb_sha256_block_sequencer;

    localparam int TMO = 100;
    localparam int LAT = 8;
`ifdef SHA256_SEQ_TIMEOUT_EN
    localparam int EXP_TMO = 1;
`else
    localparam int EXP_TMO = 0;
`endif

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] NIST_B1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
        32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] NIST_B2 = {448'h0, 64'h1c0};
    localparam logic [255:0] NIST_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] SHORT_BLK = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h0badf00d, 384'h0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  msg_word = '0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic         msg_last = 1'b0;
    logic         core_init, core_next;
    logic [511:0] core_block;
    logic         core_ready, core_digest_valid;
    logic [255:0] core_digest;
    logic [255:0] dig_data;
    logic         dig_valid;
    logic         dig_ready = 1'b1;
    logic         short_err, timeout_err;

    always #5 clk = ~clk;

    sha256_block_sequencer #(.DIGEST_W(256), .TIMEOUT_CYC(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .msg_word          (msg_word),
        .msg_valid         (msg_valid),
        .msg_ready         (msg_ready),
        .msg_last          (msg_last),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_block        (core_block),
        .core_ready        (core_ready),
        .core_digest_valid (core_digest_valid),
        .core_digest       (core_digest),
        .dig_data          (dig_data),
        .dig_valid         (dig_valid),
        .dig_ready         (dig_ready),
        .short_err         (short_err),
        .timeout_err       (timeout_err)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    // Core model: goes busy the edge after a command, finishes LAT cycles later.
    logic         cm_ready, cm_dv;
    logic [255:0] cm_h;
    int           cm_busy;
    bit           core_hold = 0;
    bit           core_stuck = 0;

    assign core_ready        = cm_ready && !core_stuck;
    assign core_digest_valid = cm_dv;
    assign core_digest       = cm_h;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cm_ready <= 1'b1;
            cm_dv    <= 1'b0;
            cm_h     <= '0;
            cm_busy  <= 0;
        end else if (core_init || core_next) begin
            cm_h     <= compress(core_init ? IV : cm_h, core_block);
            cm_ready <= 1'b0;
            cm_dv    <= 1'b0;
            cm_busy  <= LAT;
        end else if (cm_busy > 1) begin
            cm_busy <= cm_busy - 1;
        end else if (cm_busy == 1 && !core_hold) begin
            cm_busy  <= 0;
            cm_ready <= 1'b1;
            cm_dv    <= 1'b1;
        end
    end

    int           n_tests = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_xfer_cyc = 0;
    int           n_short = 0;
    int           n_tmo = 0;
    int           tmo_cyc = 0;
    bit           tmo_ready = 0;
    bit           exp_kind [$];
    logic [511:0] exp_blk [$];
    logic [255:0] exp_dig [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic bound_expired(input string name, input int cycles);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no event within %0d cycles, required one", name, cycles);
    endtask

    // Monitor: samples 2 ns after the negedge, i.e. the values the next posedge sees.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (msg_valid && msg_ready) last_xfer_cyc = cyc;
            if (core_init || core_next) begin
                if (exp_kind.size() == 0) begin
                    check("cmd_unexpected", {core_init, core_next}, 2'b00);
                end else begin
                    bit k;
                    k = exp_kind.pop_front();
                    check("cmd_kind", {core_init, core_next}, k ? 2'b10 : 2'b01);
                    check("cmd_block", core_block, exp_blk.pop_front());
                    check("cmd_latency", cyc - last_xfer_cyc, 1);
                end
            end
            if (dig_valid && dig_ready) begin
                if (exp_dig.size() == 0) check("dig_unexpected", dig_valid, 1'b0);
                else                     check("dig_data", dig_data, exp_dig.pop_front());
            end
            if (short_err) n_short++;
            if (timeout_err) begin
                n_tmo++;
                tmo_cyc   = cyc;
                tmo_ready = msg_ready;
            end
        end
    end

    task automatic send_block(input logic [511:0] blk, input int n, input bit last);
        for (int i = 0; i < n; i++) begin
            bit done;
            done      = 0;
            msg_valid = 1'b1;
            msg_word  = blk[511-32*i -: 32];
            msg_last  = last && (i == n - 1);
            for (int t = 0; t < 300 && !done; t++) begin
                #2;
                done = msg_ready;
                @(negedge clk);
            end
            if (!done) begin
                bound_expired("msg_accept", 300);
                break;
            end
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic expect_cmd(input bit is_init, input logic [511:0] blk);
        exp_kind.push_back(is_init);
        exp_blk.push_back(blk);
    endtask

    task automatic wait_drain();
        int t;
        for (t = 0; t < 1000; t++) begin
            if (exp_kind.size() == 0 && exp_dig.size() == 0) break;
            @(negedge clk);
        end
        if (t == 1000) bound_expired("drain", 1000);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ctrl", {msg_ready, core_init, core_next, dig_valid, short_err, timeout_err}, 6'b0);
        check("rst_block", core_block, '0);
        check("rst_dig", dig_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("fill_ready", msg_ready, 1'b1);
        @(negedge clk);

        // Single-block "abc"
        expect_cmd(1'b1, ABC_BLK);
        exp_dig.push_back(ABC_DIG);
        send_block(ABC_BLK, 16, 1'b1);
        wait_drain();

        // Two-block NIST vector: init then next
        expect_cmd(1'b1, NIST_B1);
        expect_cmd(1'b0, NIST_B2);
        exp_dig.push_back(NIST_DIG);
        send_block(NIST_B1, 16, 1'b0);
        send_block(NIST_B2, 16, 1'b1);
        wait_drain();

        // Early last on word 3: upper words must read back zero
        expect_cmd(1'b1, SHORT_BLK);
        exp_dig.push_back(compress(IV, SHORT_BLK));
        send_block(SHORT_BLK, 4, 1'b1);
        wait_drain();

        // Digest consumer stalls for 20 cycles
        begin
            bit ok;
            int t;
            dig_ready = 1'b0;
            expect_cmd(1'b1, ABC_BLK);
            exp_dig.push_back(ABC_DIG);
            send_block(ABC_BLK, 16, 1'b1);
            for (t = 0; t < 200; t++) begin
                @(negedge clk);
                #2;
                if (dig_valid) break;
            end
            if (t == 200) bound_expired("stall_dig_valid", 200);
            ok = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #2;
                if (!(dig_valid === 1'b1 && dig_data === ABC_DIG && msg_ready === 1'b0)) ok = 0;
            end
            check("stall_stable", ok, 1'b1);
            @(negedge clk);
            dig_ready = 1'b1;
            wait_drain();
        end

        // Reset while waiting on the core
        core_hold = 1;
        expect_cmd(1'b1, ABC_BLK);
        send_block(ABC_BLK, 16, 1'b1);
        repeat (4) @(negedge clk);
        #2;
        check("wait_ctrl", {msg_ready, dig_valid}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {msg_ready, core_init, core_next, dig_valid, short_err, timeout_err}, 6'b0);
        check("midrst_block", core_block, '0);
        check("midrst_dig", dig_data, '0);
        @(negedge clk);
        rst = 1'b0;
        core_hold = 0;
        @(negedge clk);
        expect_cmd(1'b1, ABC_BLK);
        exp_dig.push_back(ABC_DIG);
        send_block(ABC_BLK, 16, 1'b1);
        wait_drain();

`ifdef SHA256_SEQ_TIMEOUT_EN
        // Core never ready: watchdog aborts, next message starts with init
        begin
            int t;
            core_stuck = 1;
            send_block(ABC_BLK, 16, 1'b1);
            for (t = 0; t < TMO + 50; t++) begin
                if (n_tmo != 0) break;
                @(negedge clk);
            end
            if (n_tmo == 0) begin
                bound_expired("tmo_pulse", TMO + 50);
            end else begin
                check("tmo_latency", tmo_cyc - last_xfer_cyc, TMO + 1);
                check("tmo_fill_ready", tmo_ready, 1'b1);
            end
            @(negedge clk);
            core_stuck = 0;
            expect_cmd(1'b1, ABC_BLK);
            exp_dig.push_back(ABC_DIG);
            send_block(ABC_BLK, 16, 1'b1);
            wait_drain();
        end
`endif

        check("short_err_count", n_short, 1);
        check("timeout_count", n_tmo, EXP_TMO);
        check("queues_empty", exp_kind.size() + exp_dig.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
